shift_rnd_pipe: RTL and testbench

//  Multi-lane, pipelined arithmetic right-shift with selectable rounding and symmetric saturation.

---
 rtl/shift_rnd_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_shift_rnd_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rnd_pipe.sv
// shift_rnd_pipe: multi-lane, two-stage pipelined arithmetic right shift with
// selectable rounding (RNE / floor / half-up) and symmetric saturation to width_o.
// Every lane shares one valid/ready handshake and one rounding mode per beat.
// Optional saturation event counter: define SHIFT_RND_SAT_CNT_EN to build it;
// without it o_sat_cnt is tied to zero and i_sat_clr is ignored.

`default_nettype none

module shift_rnd_pipe #(
  parameter int lanes       = 4,
  parameter int width_i     = 9,
  parameter int width_o     = 8,
  parameter int width_shift = $clog2(width_i + 2),
  localparam int width_diff = width_i - width_o
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [lanes*width_i-1:0]     i_num,
  input  logic [lanes*width_shift-1:0] i_shift,
  input  logic [1:0]                   i_mode,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [lanes*width_o-1:0]     o_rnd,
  output logic [lanes-1:0]             o_sat,
  input  logic                         i_sat_clr,
  output logic [15:0]                  o_sat_cnt
);

  typedef enum logic [1:0] {
    MODE_RNE     = 2'b00,
    MODE_FLOOR   = 2'b01,
    MODE_HALF_UP = 2'b10,
    MODE_RSVD    = 2'b11
  } rndMode_e;

  // Total shift carries one extra bit so i_shift + width_diff never wraps.
  localparam int TOT_W = width_shift + 1;
  localparam logic [TOT_W-1:0] DIFF_T    = TOT_W'(width_diff);
  localparam logic [TOT_W-1:0] WIDTH_I_T = TOT_W'(width_i);

  // Symmetric clamp limits; the most negative code is never produced.
  localparam logic signed [width_o:0] MAX_V = (width_o + 1)'(2 ** (width_o - 1) - 1);
  localparam logic signed [width_o:0] MIN_V = -MAX_V;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1Valid_q;
  logic oValid_q;
  logic s2Adv;
  logic s1Load;

  assign s2Adv   = !oValid_q || i_ready;
  assign o_ready = !s1Valid_q || s2Adv;
  assign s1Load  = i_valid && o_ready;
  assign o_valid = oValid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: shift, extract round (R) and sticky (S) bits per lane
  // ---------------------------------------------------------------------------
  logic signed [width_i-1:0] laneX   [lanes];
  logic [TOT_W-1:0]          laneTot [lanes];
  logic signed [width_i-1:0] laneShr [lanes];
  logic signed [width_o:0]   sh_d    [lanes];
  logic [lanes-1:0]          r_d;
  logic [lanes-1:0]          s_d;
  logic [lanes-1:0]          zero_d;

  logic signed [width_o:0]   sh_q    [lanes];
  logic [lanes-1:0]          r_q;
  logic [lanes-1:0]          s_q;
  logic [lanes-1:0]          zero_q;
  rndMode_e                  mode_q;

  // Per-lane shift plus R = x[tot-1] and S = |x[tot-2:0]; shifting past the sign forces zero.
  always_comb begin
    for (int k = 0; k < lanes; k++) begin
      laneX[k]   = i_num[k*width_i +: width_i];
      laneTot[k] = TOT_W'(i_shift[k*width_shift +: width_shift]) + DIFF_T;
      laneShr[k] = laneX[k] >>> laneTot[k];
      sh_d[k]    = (width_o + 1)'(laneShr[k]);
      zero_d[k]  = laneTot[k] > WIDTH_I_T;
      r_d[k]     = 1'b0;
      s_d[k]     = 1'b0;
      for (int j = 0; j < width_i; j++) begin
        if (laneTot[k] == TOT_W'(j + 1)) begin
          r_d[k] = laneX[k][j];
        end
        if (TOT_W'(j + 1) < laneTot[k]) begin
          s_d[k] = s_d[k] | laneX[k][j];
        end
      end
    end
  end

  // Stage 1 occupancy: refilled whenever the stage can accept a beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1Valid_q <= 1'b0;
    end else if (o_ready) begin
      s1Valid_q <= i_valid;
    end
  end

  // Stage 1 payload: captured only on an input transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < lanes; k++) begin
        sh_q[k] <= '0;
      end
      r_q    <= '0;
      s_q    <= '0;
      zero_q <= '0;
      mode_q <= MODE_RNE;
    end else if (s1Load) begin
      for (int k = 0; k < lanes; k++) begin
        sh_q[k] <= sh_d[k];
      end
      r_q    <= r_d;
      s_q    <= s_d;
      zero_q <= zero_d;
      mode_q <= rndMode_e'(i_mode);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round increment, add, symmetric clamp
  // ---------------------------------------------------------------------------
  logic [lanes-1:0]          inc;
  logic signed [width_o:0]   sum [lanes];
  logic [lanes*width_o-1:0]  rnd_d;
  logic [lanes-1:0]          sat_d;
  logic [lanes*width_o-1:0]  rnd_q;
  logic [lanes-1:0]          sat_q;

  // Choose the increment by mode (reserved behaves as RNE), then clamp to +/-MAX_V.
  always_comb begin
    for (int k = 0; k < lanes; k++) begin
      case (mode_q)
        MODE_FLOOR:   inc[k] = 1'b0;
        MODE_HALF_UP: inc[k] = r_q[k];
        default:      inc[k] = r_q[k] & (sh_q[k][0] | s_q[k]);
      endcase
      sum[k]   = sh_q[k] + $signed({{width_o{1'b0}}, inc[k]});
      sat_d[k] = 1'b0;
      rnd_d[k*width_o +: width_o] = sum[k][width_o-1:0];
      if (zero_q[k]) begin
        rnd_d[k*width_o +: width_o] = '0;
      end else if (sum[k] > MAX_V) begin
        rnd_d[k*width_o +: width_o] = MAX_V[width_o-1:0];
        sat_d[k] = 1'b1;
      end else if (sum[k] < MIN_V) begin
        rnd_d[k*width_o +: width_o] = MIN_V[width_o-1:0];
        sat_d[k] = 1'b1;
      end
    end
  end

  // Output valid advances whenever downstream is free or accepting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oValid_q <= 1'b0;
    end else if (s2Adv) begin
      oValid_q <= s1Valid_q;
    end
  end

  // Output payload loads only with a real beat, so it holds under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rnd_q <= '0;
      sat_q <= '0;
    end else if (s2Adv && s1Valid_q) begin
      rnd_q <= rnd_d;
      sat_q <= sat_d;
    end
  end

  assign o_rnd = rnd_q;
  assign o_sat = sat_q;

  // ---------------------------------------------------------------------------
  // Optional saturation event counter
  // ---------------------------------------------------------------------------
`ifdef SHIFT_RND_SAT_CNT_EN
  localparam int POP_W = $clog2(lanes + 1);

  logic [15:0]      satCnt_q;
  logic [15:0]      satCnt_d;
  logic [POP_W-1:0] satPop;
  logic [16:0]      satSum;
  logic             outXfer;

  assign outXfer = oValid_q && i_ready;

  // Add the clamped-lane count of each delivered beat, sticking at all-ones; clear has priority.
  always_comb begin
    satPop = '0;
    for (int k = 0; k < lanes; k++) begin
      satPop = satPop + POP_W'(sat_q[k]);
    end
    satSum   = {1'b0, satCnt_q} + 17'(satPop);
    satCnt_d = satCnt_q;
    if (i_sat_clr) begin
      satCnt_d = '0;
    end else if (outXfer) begin
      satCnt_d = satSum[16] ? 16'hFFFF : satSum[15:0];
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      satCnt_q <= '0;
    end else begin
      satCnt_q <= satCnt_d;
    end
  end

  assign o_sat_cnt = satCnt_q;
`else
  logic unusedSatClr;

  assign unusedSatClr = i_sat_clr;
  assign o_sat_cnt    = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_rnd_pipe.sv
// tb_shift_rnd_pipe: directed and randomized checks of shift_rnd_pipe against an
// arithmetic reference model (exact division by 2^tot, then rounding and clamping).
// Honours SHIFT_RND_SAT_CNT_EN for the saturation counter expectations.

`timescale 1ns/1ps

module tb_shift_rnd_pipe;

  localparam int LANES = 4;
  localparam int WI    = 9;
  localparam int WO    = 8;
  localparam int WS    = $clog2(WI + 2);
  localparam int WD    = WI - WO;

  typedef struct packed {
    logic [LANES*WO-1:0] rnd;
    logic [LANES-1:0]    sat;
  } beat_t;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic                  i_valid;
  logic                  o_ready;
  logic [LANES*WI-1:0]   i_num;
  logic [LANES*WS-1:0]   i_shift;
  logic [1:0]            i_mode;
  logic                  o_valid;
  logic                  i_ready;
  logic [LANES*WO-1:0]   o_rnd;
  logic [LANES-1:0]      o_sat;
  logic                  i_sat_clr;
  logic [15:0]           o_sat_cnt;

  int    nChecks      = 0;
  int    nMiscompares = 0;
  int    expCnt       = 0;
  beat_t expQ[$];

  shift_rnd_pipe #(
    .lanes   (LANES),
    .width_i (WI),
    .width_o (WO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_num     (i_num),
    .i_shift   (i_shift),
    .i_mode    (i_mode),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_rnd     (o_rnd),
    .o_sat     (o_sat),
    .i_sat_clr (i_sat_clr),
    .o_sat_cnt (o_sat_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference: value = x / 2^tot exactly; round the remainder by mode; clamp to +/-(2^(WO-1)-1).
  function automatic beat_t refBeat(input logic [LANES*WI-1:0] num,
                                    input logic [LANES*WS-1:0] shf,
                                    input logic [1:0] mode);
    beat_t b;
    int x, tot, p, q, rem, v, maxV;
    bit up, sat;
    b    = '0;
    maxV = (1 << (WO - 1)) - 1;
    for (int k = 0; k < LANES; k++) begin
      x   = int'($signed(num[k*WI +: WI]));
      tot = int'(shf[k*WS +: WS]) + WD;
      sat = 1'b0;
      if (tot > WI) begin
        v = 0;
      end else begin
        p = 1 << tot;
        q = x / p;
        if ((x % p) != 0 && x < 0) q = q - 1;
        rem = x - q * p;
        up  = 1'b0;
        if (tot > 0) begin
          case (mode)
            2'b01:   up = 1'b0;
            2'b10:   up = (2 * rem >= p);
            default: up = (2 * rem > p) || ((2 * rem == p) && ((q % 2) != 0));
          endcase
        end
        v = q + int'(up);
        if (v > maxV) begin
          v = maxV;  sat = 1'b1;
        end else if (v < -maxV) begin
          v = -maxV; sat = 1'b1;
        end
      end
      b.rnd[k*WO +: WO] = v[WO-1:0];
      b.sat[k]          = sat;
    end
    return b;
  endfunction

  function automatic logic [LANES*WI-1:0] packNum(input int a, input int b, input int c, input int d);
    logic [LANES*WI-1:0] r;
    r[0*WI +: WI] = a[WI-1:0];
    r[1*WI +: WI] = b[WI-1:0];
    r[2*WI +: WI] = c[WI-1:0];
    r[3*WI +: WI] = d[WI-1:0];
    return r;
  endfunction

  function automatic logic [LANES*WO-1:0] packRnd(input int a, input int b, input int c, input int d);
    logic [LANES*WO-1:0] r;
    r[0*WO +: WO] = a[WO-1:0];
    r[1*WO +: WO] = b[WO-1:0];
    r[2*WO +: WO] = c[WO-1:0];
    r[3*WO +: WO] = d[WO-1:0];
    return r;
  endfunction

  function automatic logic [LANES*WS-1:0] packShift(input int a, input int b, input int c, input int d);
    logic [LANES*WS-1:0] r;
    r[0*WS +: WS] = a[WS-1:0];
    r[1*WS +: WS] = b[WS-1:0];
    r[2*WS +: WS] = c[WS-1:0];
    r[3*WS +: WS] = d[WS-1:0];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setRandomData();
    for (int k = 0; k < LANES; k++) begin
      i_num[k*WI +: WI]   = WI'($urandom);
      i_shift[k*WS +: WS] = WS'($urandom);
    end
    i_mode = 2'($urandom);
  endtask

  // Drive handshake inputs, then at the falling edge score the transfers the next rising edge will make.
  task automatic applyStimulus(input bit valid, input bit ready, output bit accepted);
    bit    outX;
    beat_t e;
    i_valid  = valid;
    i_ready  = ready;
    accepted = 1'b0;
    @(negedge i_clk);
    if (i_rst_n) begin
      checkOutput("sat_cnt", {48'h0, o_sat_cnt}, 64'(expCnt));
      outX     = o_valid && i_ready;
      accepted = i_valid && o_ready;
      if (outX) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_beat", {63'h0, o_valid}, 64'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rnd", {32'h0, o_rnd}, {32'h0, e.rnd});
          checkOutput("sat", {60'h0, o_sat}, {60'h0, e.sat});
`ifdef SHIFT_RND_SAT_CNT_EN
          if (!i_sat_clr) begin
            expCnt = expCnt + $countones(e.sat);
            if (expCnt > 65535) expCnt = 65535;
          end
`endif
        end
      end
`ifdef SHIFT_RND_SAT_CNT_EN
      if (i_sat_clr) expCnt = 0;
`endif
      if (accepted) expQ.push_back(refBeat(i_num, i_shift, i_mode));
    end
    @(posedge i_clk);
    #1;
  endtask

  // One beat into an empty pipeline: absent after one cycle, present with constant values after two.
  task automatic directedBeat(input string tag, input logic [LANES*WI-1:0] num,
                              input logic [LANES*WS-1:0] shf, input logic [1:0] mode,
                              input logic [LANES*WO-1:0] expRnd, input logic [LANES-1:0] expSat);
    bit acc;
    i_num   = num;
    i_shift = shf;
    i_mode  = mode;
    applyStimulus(1'b1, 1'b1, acc);
    checkOutput({tag, "_acc"}, 64'(acc), 64'h1);
    checkOutput({tag, "_lat1"}, 64'(o_valid), 64'h0);
    applyStimulus(1'b0, 1'b1, acc);
    checkOutput({tag, "_lat2"}, 64'(o_valid), 64'h1);
    checkOutput({tag, "_rnd"}, 64'(o_rnd), 64'(expRnd));
    checkOutput({tag, "_sat"}, 64'(o_sat), 64'(expSat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int expCnt2;

`ifdef SHIFT_RND_SAT_CNT_EN
    expCnt2 = 2;
`else
    expCnt2 = 0;
`endif

    i_rst_n   = 1'b1;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_num     = '0;
    i_shift   = '0;
    i_mode    = 2'b00;
    i_sat_clr = 1'b0;

    // Asynchronous reset values.
    #2 i_rst_n = 1'b0;
    #2;
    checkOutput("rst_valid", 64'(o_valid), 64'h0);
    checkOutput("rst_rnd", 64'(o_rnd), 64'h0);
    checkOutput("rst_sat", 64'(o_sat), 64'h0);
    checkOutput("rst_cnt", 64'(o_sat_cnt), 64'h0);
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("rst_ready", 64'(o_ready), 64'h1);

    // Rounding modes with tot = 1.
    directedBeat("rne",   packNum(3, 5, -3, -5), '0, 2'b00, packRnd(2, 2, -2, -2), 4'b0000);
    directedBeat("floor", packNum(3, 5, -3, -5), '0, 2'b01, packRnd(1, 2, -2, -3), 4'b0000);
    directedBeat("hup",   packNum(3, 5, -3, -5), '0, 2'b10, packRnd(2, 3, -1, -2), 4'b0000);
    directedBeat("rsvd",  packNum(3, 5, -3, -5), '0, 2'b11, packRnd(2, 2, -2, -2), 4'b0000);

    // Symmetric saturation and counter.
    directedBeat("sat", packNum(255, -256, 254, 0), '0, 2'b00, packRnd(127, -127, 127, 0), 4'b0011);
    applyStimulus(1'b0, 1'b1, acc);
    checkOutput("sat_cnt_two", 64'(o_sat_cnt), 64'(expCnt2));

    // Oversized shift gives zero; tot = 2 ties.
    directedBeat("big_rne", packNum(-1, 6, 0, 0), packShift(15, 1, 0, 0), 2'b00, packRnd(0, 2, 0, 0), 4'b0000);
    directedBeat("big_flr", packNum(-1, 6, 0, 0), packShift(15, 1, 0, 0), 2'b01, packRnd(0, 1, 0, 0), 4'b0000);
    directedBeat("big_hup", packNum(-1, 6, 0, 0), packShift(15, 1, 0, 0), 2'b10, packRnd(0, 2, 0, 0), 4'b0000);
    applyStimulus(1'b0, 1'b1, acc);

    // Backpressure: downstream stalled for four cycles while three beats are offered.
    setRandomData();
    applyStimulus(1'b1, 1'b0, acc);
    checkOutput("bp_acc_a", 64'(acc), 64'h1);
    setRandomData();
    applyStimulus(1'b1, 1'b0, acc);
    checkOutput("bp_acc_b", 64'(acc), 64'h1);
    setRandomData();
    checkOutput("bp_ready_low", 64'(o_ready), 64'h0);
    checkOutput("bp_valid", 64'(o_valid), 64'h1);
    applyStimulus(1'b1, 1'b0, acc);
    checkOutput("bp_stall1", 64'(acc), 64'h0);
    checkOutput("bp_hold1", 64'(o_rnd), 64'(expQ[0].rnd));
    applyStimulus(1'b1, 1'b0, acc);
    checkOutput("bp_stall2", 64'(acc), 64'h0);
    checkOutput("bp_hold2", 64'(o_rnd), 64'(expQ[0].rnd));
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) applyStimulus(1'b1, 1'b1, acc);
    checkOutput("bp_acc_c", 64'(acc), 64'h1);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) applyStimulus(1'b0, 1'b1, acc);
    checkOutput("bp_drain", 64'(expQ.size()), 64'h0);

    // Randomized traffic with random backpressure and occasional counter clears.
    for (int n = 0; n < 600; n++) begin
      setRandomData();
      i_sat_clr = ($urandom_range(0, 19) == 0);
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, acc);
    end
    i_sat_clr = 1'b0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) applyStimulus(1'b0, 1'b1, acc);
    checkOutput("rand_drain", 64'(expQ.size()), 64'h0);

    // Reset with two beats in flight.
    setRandomData();
    applyStimulus(1'b1, 1'b0, acc);
    setRandomData();
    applyStimulus(1'b1, 1'b0, acc);
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(o_valid), 64'h0);
    checkOutput("mid_rst_cnt", 64'(o_sat_cnt), 64'h0);
    expQ.delete();
    expCnt = 0;
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    directedBeat("post_rst", packNum(3, 5, -3, -5), '0, 2'b10, packRnd(2, 3, -1, -2), 4'b0000);
    for (int i = 0; i < 10 && expQ.size() != 0; i++) applyStimulus(1'b0, 1'b1, acc);
    checkOutput("final_drain", 64'(expQ.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
    $finish;
  end

endmodule
